seq_alu: RTL and testbench

- Parametrised, handshaked successor to the single-cycle combinational ALU.
- Executes all eight RV32I funct3 operations, including SLL/SRL/SRA and SLT/SLTU, which the previous generation left as placeholders.
- Shifts run on an iterative multi-cycle shifter; all results are registered behind a valid/ready interface.
- Sits between the register-read stage and writeback.

---
 rtl/seq_alu.sv | 146 ++++++++++++++
 tb/tb_seq_alu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential RV32I-style ALU with a valid/ready handshake on both sides.
// Non-shift operations finish in one cycle. Shifts run on an iterative
// shifter that moves up to SHIFT_STEP bit positions per cycle.
module seq_alu #(
   parameter int W          = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic         iClk,
   input  logic         iRstN,
   input  logic         iValid,
   output logic         oReady,
   input  logic [W-1:0] iDataA,
   input  logic [W-1:0] iDataB,
   input  logic [2:0]   iFunct3,
   input  logic [6:0]   iFunct7,
   output logic         oValid,
   input  logic         iReady,
   output logic [W-1:0] oData,
   output logic         oZero
);

   // LW bits hold any shift amount. CW adds one bit so SHIFT_STEP == W still fits.
   localparam int LW = $clog2(W);
   localparam int CW = LW + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} StateT;
   typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} ShiftKindT;

   StateT         state;
   ShiftKindT     shiftKind;
   logic [W-1:0]  workReg;
   logic [CW-1:0] counter;

   logic [LW-1:0] shamt;
   logic          isShift;
   logic          isSub;
   logic [W-1:0]  addOperand;
   logic [W-1:0]  sum;
   logic [W-1:0]  opResult;
   logic [CW-1:0] stepK;
   logic [W-1:0]  shifted;
   logic          unusedFunct7;

   // Only bit 5 of funct7 selects anything. The remaining bits are deliberately dropped.
   assign unusedFunct7 = ^{iFunct7[6], iFunct7[4:0]};

   assign shamt   = iDataB[LW-1:0];
   assign isShift = (iFunct3 == 3'b001) || (iFunct3 == 3'b101);
   assign isSub   = (iFunct3 == 3'b000) && iFunct7[5];

   // A single shared adder serves ADD and SUB.
   // SUB is formed as A + ~B + 1, with the +1 injected as the carry-in.
   assign addOperand = isSub ? ~iDataB : iDataB;
   assign sum        = iDataA + addOperand + {{(W-1){1'b0}}, isSub};

   // One-cycle result for every operation that does not need the iterative shifter.
   // A shift only reaches this path when its shift amount is zero, so it returns A unchanged.
   always_comb begin
      opResult = '0;
      case (iFunct3)
         3'b000:  opResult = sum;
         3'b001:  opResult = iDataA;
         3'b010:  opResult = {{(W-1){1'b0}}, ($signed(iDataA) < $signed(iDataB))};
         3'b011:  opResult = {{(W-1){1'b0}}, (iDataA < iDataB)};
         3'b100:  opResult = iDataA ^ iDataB;
         3'b101:  opResult = iDataA;
         3'b110:  opResult = iDataA | iDataB;
         default: opResult = iDataA & iDataB;
      endcase
   end

   // Per-cycle shift distance is min(SHIFT_STEP, remaining), so the final step never overshoots.
   // For SRA, the MSB of the working register always equals A's sign bit, so an arithmetic shift fills correctly.
   always_comb begin
      stepK   = (counter > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : counter;
      shifted = workReg;
      case (shiftKind)
         SK_SLL:  shifted = workReg << stepK;
         SK_SRL:  shifted = workReg >> stepK;
         SK_SRA:  shifted = $signed(workReg) >>> stepK;
         default: shifted = workReg;
      endcase
   end

   // Control FSM with registered handshake outputs.
   // A result is held in oData/oZero until the consumer takes it.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state     <= IDLE;
         shiftKind <= SK_SLL;
         workReg   <= '0;
         counter   <= '0;
         oReady    <= 1'b1;
         oValid    <= 1'b0;
         oData     <= '0;
         oZero     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (iValid && oReady) begin
                  oReady <= 1'b0;
                  if (isShift && (shamt != '0)) begin
                     workReg <= iDataA;
                     counter <= {1'b0, shamt};
                     if (iFunct3 == 3'b001)
                        shiftKind <= SK_SLL;
                     else if (iFunct7[5])
                        shiftKind <= SK_SRA;
                     else
                        shiftKind <= SK_SRL;
                     state <= SHIFT;
                  end else begin
                     oData  <= opResult;
                     oZero  <= (opResult == '0);
                     oValid <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            SHIFT: begin
               workReg <= shifted;
               counter <= counter - stepK;
               if (counter == stepK) begin
                  oData  <= shifted;
                  oZero  <= (shifted == '0);
                  oValid <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (iReady) begin
                  oValid <= 1'b0;
                  oReady <= 1'b1;
                  state  <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               oValid <= 1'b0;
               oReady <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu.
// Two instances share the clock, reset and operand buses: one shifts 1 bit per cycle, the other 4 bits per cycle.
// useFour selects which instance receives the handshake and which instance's outputs are observed.
module tb_seq_alu;

   logic        iClk = 1'b0;
   logic        iRstN = 1'b1;
   logic        reqValid = 1'b0;
   logic        relReady = 1'b0;
   logic        useFour = 1'b0;
   logic [31:0] iDataA = '0;
   logic [31:0] iDataB = '0;
   logic [2:0]  iFunct3 = '0;
   logic [6:0]  iFunct7 = '0;

   logic        valid1, valid4, ready1, ready4;
   logic        oReady1, oReady4, oValid1, oValid4, oZero1, oZero4;
   logic [31:0] oData1, oData4;
   logic        obsReady, obsValid, obsZero;
   logic [31:0] obsData;

   int checks = 0;
   int failures = 0;

   always #5 iClk = ~iClk;

   assign valid1   = reqValid & ~useFour;
   assign valid4   = reqValid & useFour;
   assign ready1   = relReady & ~useFour;
   assign ready4   = relReady & useFour;
   assign obsReady = useFour ? oReady4 : oReady1;
   assign obsValid = useFour ? oValid4 : oValid1;
   assign obsZero  = useFour ? oZero4  : oZero1;
   assign obsData  = useFour ? oData4  : oData1;

   seq_alu #(.W(32), .SHIFT_STEP(1)) dutStep1 (
      .iClk(iClk), .iRstN(iRstN), .iValid(valid1), .oReady(oReady1),
      .iDataA(iDataA), .iDataB(iDataB), .iFunct3(iFunct3), .iFunct7(iFunct7),
      .oValid(oValid1), .iReady(ready1), .oData(oData1), .oZero(oZero1)
   );

   seq_alu #(.W(32), .SHIFT_STEP(4)) dutStep4 (
      .iClk(iClk), .iRstN(iRstN), .iValid(valid4), .oReady(oReady4),
      .iDataA(iDataA), .iDataB(iDataB), .iFunct3(iFunct3), .iFunct7(iFunct7),
      .oValid(oValid4), .iReady(ready4), .oData(oData4), .oZero(oZero4)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Presents one request for exactly one rising edge.
   // The request is accepted on that edge; the caller makes sure oReady is high beforehand.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] f3, input logic [6:0] f7);
      @(negedge iClk);
      iDataA   = a;
      iDataB   = b;
      iFunct3  = f3;
      iFunct7  = f7;
      reqValid = 1'b1;
      @(posedge iClk);
      #1;
      reqValid = 1'b0;
   endtask

   // Counts rising edges from the accept edge (counted as 1) until oValid rises.
   // The wait gives up after 100 edges.
   task automatic awaitResult(output int lat, output logic readyLeaked);
      lat = 1;
      readyLeaked = obsReady;
      while (!obsValid && lat < 100) begin
         @(posedge iClk);
         #1;
         lat++;
         if (obsReady) readyLeaked = 1'b1;
      end
   endtask

   task automatic releaseResult();
      @(negedge iClk);
      relReady = 1'b1;
      @(posedge iClk);
      #1;
      relReady = 1'b0;
   endtask

   task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] expData, input int expLat);
      int   lat;
      logic leaked;
      applyStimulus(a, b, f3, f7);
      awaitResult(lat, leaked);
      checkOutput({tag, "_lat"},   lat, expLat);
      checkOutput({tag, "_data"},  obsData, expData);
      checkOutput({tag, "_zero"},  {31'd0, obsZero}, {31'd0, (expData == 32'd0)});
      checkOutput({tag, "_busy"},  {31'd0, leaked}, 32'd0);
      releaseResult();
      checkOutput({tag, "_idle"},  {obsValid, obsReady}, 32'd1);
   endtask

   initial begin
      int   lat;
      logic leaked;

      // Reset values, checked while reset is held and again after release.
      #2 iRstN = 1'b0;
      #10;
      checkOutput("rst_valid", {31'd0, obsValid}, 32'd0);
      checkOutput("rst_data",  obsData, 32'd0);
      checkOutput("rst_zero",  {31'd0, obsZero}, 32'd1);
      @(negedge iClk);
      iRstN = 1'b1;
      #1;
      checkOutput("rst_ready", {31'd0, obsReady}, 32'd1);

      // Arithmetic and logic on the 1-bit-per-cycle instance.
      runOp("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 3'b000, 7'h00, 32'h8000_0000, 1);
      runOp("sub_zero",  32'h1234_5678, 32'h1234_5678, 3'b000, 7'h20, 32'h0000_0000, 1);
      runOp("add_f7bits",32'd10,        32'd20,        3'b000, 7'h5F, 32'd30,        1);
      runOp("slt",       32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 7'h00, 32'h0000_0001, 1);
      runOp("sltu",      32'hFFFF_FFFF, 32'h0000_0001, 3'b011, 7'h00, 32'h0000_0000, 1);
      runOp("sltu_f7",   32'h0000_0005, 32'hFFFF_FFFD, 3'b011, 7'h20, 32'h0000_0001, 1);
      runOp("slt_neg",   32'h0000_0005, 32'hFFFF_FFFD, 3'b010, 7'h00, 32'h0000_0000, 1);
      runOp("xor_f7",    32'hFF00_FF00, 32'h0FF0_0FF0, 3'b100, 7'h20, 32'hF0F0_F0F0, 1);
      runOp("or",        32'hF000_0000, 32'h0000_000F, 3'b110, 7'h00, 32'hF000_000F, 1);
      runOp("and",       32'hFF00_FF00, 32'h0FF0_0FF0, 3'b111, 7'h00, 32'h0F00_0F00, 1);
      runOp("sll_zero",  32'hDEAD_BEEF, 32'h0000_0020, 3'b001, 7'h00, 32'hDEAD_BEEF, 1);
      runOp("sll4_s1",   32'h0000_00F1, 32'h0000_0004, 3'b001, 7'h00, 32'h0000_0F10, 5);
      runOp("sra31_s1",  32'h8000_0000, 32'h0000_001F, 3'b101, 7'h20, 32'hFFFF_FFFF, 32);

      // The same kinds of shift on the 4-bits-per-cycle instance.
      useFour = 1'b1;
      runOp("sra31_s4",  32'h8000_0000, 32'h0000_001F, 3'b101, 7'h20, 32'hFFFF_FFFF, 9);
      runOp("srl31_s4",  32'h8000_0000, 32'h0000_001F, 3'b101, 7'h00, 32'h0000_0001, 9);
      runOp("sll5_s4",   32'h0000_00F1, 32'h0000_0005, 3'b001, 7'h00, 32'h0000_1E20, 3);
      runOp("sll4_s4",   32'h0000_00F1, 32'h0000_0004, 3'b001, 7'h00, 32'h0000_0F10, 2);
      useFour = 1'b0;

      // Backpressure: while the result is held, new requests must be ignored.
      applyStimulus(32'd3, 32'd4, 3'b000, 7'h00);
      awaitResult(lat, leaked);
      checkOutput("bp_lat", lat, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge iClk);
         iDataA   = 32'd100;
         iDataB   = 32'd200;
         reqValid = 1'b1;
         @(posedge iClk);
         #1;
         checkOutput("bp_hold", {obsValid, obsReady, obsData[29:0]}, {2'b10, 30'd7});
      end
      reqValid = 1'b0;
      releaseResult();
      checkOutput("bp_release", {obsValid, obsReady}, 32'd1);
      checkOutput("bp_kept", obsData, 32'd7);
      runOp("after_bp",  32'd1, 32'd1, 3'b000, 7'h00, 32'd2, 1);

      // Asynchronous reset in the middle of a long shift.
      applyStimulus(32'h8000_0000, 32'h0000_001F, 3'b101, 7'h20);
      repeat (5) @(posedge iClk);
      #3 iRstN = 1'b0;
      #1;
      checkOutput("arst_valid", {31'd0, obsValid}, 32'd0);
      checkOutput("arst_data",  obsData, 32'd0);
      checkOutput("arst_zero",  {31'd0, obsZero}, 32'd1);
      @(negedge iClk);
      iRstN = 1'b1;
      #1;
      checkOutput("arst_ready", {31'd0, obsReady}, 32'd1);
      runOp("after_arst", 32'd5, 32'd6, 3'b000, 7'h00, 32'd11, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
